// File: rtl/sm2_point_cal_unit.sv
// sm2_point_cal_unit
//   Instruction-driven SM2 point arithmetic engine. Each round executes three
//   16-bit instructions over twelve 256-bit field registers. It supports
//   modular mul/add/sub mod P, register load and the FIN copy X2/Y2/Z2 -> X0/Y0/Z0.
//   All slots read the register state from the start of the round. Their
//   results are held in per-slot shadow buffers and committed together.
//
//   Ports:
//     clk              clock
//     rst_n            synchronous active-low reset
//     ins_0_i..ins_2_i instruction slots 0..2 {op[1:0], type[1:0], a, b, r}
//     ins_vld_i        one-cycle strobe, accepted only in IDLE
//     data_path_i      load data for UPDT_REG, captured at round start
//     var_x2_o/y2/z2   live copies of registers X2, Y2, Z2
//     intr_cal_done_o  one-cycle round-complete pulse
//
//   Optional build macro SM2_BASE_POINT_INIT_EN: when defined, reset preloads
//   X0/X1 = Gx, Y0/Y1 = Gy, Z0/Z1 = 1 (SM2 base point).
module sm2_point_cal_unit (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [15:0]  ins_0_i,
  input  logic [15:0]  ins_1_i,
  input  logic [15:0]  ins_2_i,
  input  logic         ins_vld_i,
  input  logic [255:0] data_path_i,
  output logic [255:0] var_x2_o,
  output logic [255:0] var_y2_o,
  output logic [255:0] var_z2_o,
  output logic         intr_cal_done_o
);

  localparam logic [255:0] P     = 256'hFFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF00000000FFFFFFFFFFFFFFFF;
  localparam logic [256:0] P_EXT = {1'b0, P};
`ifdef SM2_BASE_POINT_INIT_EN
  localparam logic [255:0] GX = 256'h32C4AE2C1F1981195F9904466A39C9948FE30BBFF2660BE1715A4589334C74C7;
  localparam logic [255:0] GY = 256'hBC3736A2F4F6779C59BDCEE36B692153D0A9877CC62A474002DF32E52139F0A0;
`endif

  typedef enum logic [1:0] {IDLE, EXEC, COMMIT} state_t;

  state_t       state_q, state_d;
  logic [255:0] regs_q      [12];
  logic [255:0] regs_commit [12];
  logic [15:0]  ins_q       [3];
  logic [255:0] data_q;
  logic [1:0]   slot_q;
  logic [7:0]   bit_q;
  logic [255:0] acc_q;
  logic [255:0] sh_val_q    [3];
  logic [3:0]   sh_dst_q    [3];
  logic [2:0]   sh_wen_q;
  logic         fin_q;
  logic         done_q;

  logic [15:0]  cur;
  logic [255:0] opnd_a, opnd_b, add_res, sub_res, dbl_red, addend, mul_res, slot_res;
  logic [256:0] add_sum, sub_diff, mul_dbl, mul_sum;
  logic         is_mul, slot_last, slot_wen, slot_fin;

  // Registers only change at commit, so reading regs_q during EXEC sees the
  // round-start snapshot without a separate copy of the bank.
  always_comb begin
    cur    = ins_q[slot_q];
    opnd_a = (cur[11:8] < 4'd12) ? regs_q[cur[11:8]] : '0;
    opnd_b = (cur[7:4]  < 4'd12) ? regs_q[cur[7:4]]  : '0;

    // Reduced operands keep every sum below 2P, so one conditional correction suffices.
    add_sum  = {1'b0, opnd_a} + {1'b0, opnd_b};
    add_res  = (add_sum >= P_EXT) ? add_sum[255:0] - P : add_sum[255:0];
    sub_diff = {1'b0, opnd_a} - {1'b0, opnd_b};
    sub_res  = sub_diff[256] ? sub_diff[255:0] + P : sub_diff[255:0];

    // One MSB-first step of interleaved multiply: acc = 2*acc + b[i]*a (mod P).
    mul_dbl = {acc_q, 1'b0};
    dbl_red = (mul_dbl >= P_EXT) ? mul_dbl[255:0] - P : mul_dbl[255:0];
    addend  = opnd_b[bit_q] ? opnd_a : '0;
    mul_sum = {1'b0, dbl_red} + {1'b0, addend};
    mul_res = (mul_sum >= P_EXT) ? mul_sum[255:0] - P : mul_sum[255:0];

    is_mul    = (cur[13:12] == 2'b00) && (cur[15:14] == 2'b00);
    slot_last = !is_mul || (bit_q == 8'd0);

    slot_wen = 1'b0;
    slot_res = '0;
    slot_fin = 1'b0;
    case (cur[13:12])
      2'b00: begin
        case (cur[15:14])
          2'b00:   begin slot_wen = 1'b1; slot_res = mul_res; end
          2'b01:   begin slot_wen = 1'b1; slot_res = add_res; end
          2'b10:   begin slot_wen = 1'b1; slot_res = sub_res; end
          default: ;
        endcase
      end
      2'b01:   begin slot_wen = 1'b1; slot_res = data_q; end
      2'b10:   slot_fin = 1'b1;
      default: ;
    endcase
  end

  // Commit image: later slots overwrite earlier ones, then FIN copies the
  // freshly committed X2/Y2/Z2 into X0/Y0/Z0.
  always_comb begin
    for (int i = 0; i < 12; i++) regs_commit[i] = regs_q[i];
    for (int s = 0; s < 3; s++) begin
      if (sh_wen_q[s] && (sh_dst_q[s] < 4'd12)) regs_commit[sh_dst_q[s]] = sh_val_q[s];
    end
    if (fin_q) begin
      regs_commit[6] = regs_commit[0];
      regs_commit[7] = regs_commit[1];
      regs_commit[8] = regs_commit[2];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ins_vld_i) state_d = EXEC;
      EXEC:    if (slot_last && (slot_q == 2'd2)) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      slot_q   <= 2'd0;
      bit_q    <= 8'hFF;
      acc_q    <= '0;
      sh_wen_q <= '0;
      fin_q    <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < 12; i++) regs_q[i] <= '0;
`ifdef SM2_BASE_POINT_INIT_EN
      regs_q[6]  <= GX;
      regs_q[9]  <= GX;
      regs_q[7]  <= GY;
      regs_q[10] <= GY;
      regs_q[8]  <= 256'd1;
      regs_q[11] <= 256'd1;
`endif
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ins_vld_i) begin
            ins_q[0] <= ins_0_i;
            ins_q[1] <= ins_1_i;
            ins_q[2] <= ins_2_i;
            data_q   <= data_path_i;
            slot_q   <= 2'd0;
            bit_q    <= 8'hFF;
            acc_q    <= '0;
            sh_wen_q <= '0;
            fin_q    <= 1'b0;
          end
        end
        EXEC: begin
          if (!slot_last) begin
            acc_q <= mul_res;
            bit_q <= bit_q - 8'd1;
          end else begin
            sh_wen_q[slot_q] <= slot_wen;
            sh_dst_q[slot_q] <= cur[3:0];
            sh_val_q[slot_q] <= slot_res;
            if (slot_fin) fin_q <= 1'b1;
            slot_q <= slot_q + 2'd1;
            acc_q  <= '0;
            bit_q  <= 8'hFF;
          end
        end
        COMMIT: begin
          for (int i = 0; i < 12; i++) regs_q[i] <= regs_commit[i];
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign var_x2_o        = regs_q[0];
  assign var_y2_o        = regs_q[1];
  assign var_z2_o        = regs_q[2];
  assign intr_cal_done_o = done_q;

endmodule

// File: tb/tb_sm2_point_cal_unit.sv
// tb_sm2_point_cal_unit
//   Self-checking bench for sm2_point_cal_unit. It runs directed rounds and
//   randomized rounds. Each round is compared against an arithmetic model of
//   the register bank: X2/Y2/Z2, latency and done-pulse width.
module tb_sm2_point_cal_unit;

  localparam logic [255:0] P = 256'hFFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF00000000FFFFFFFFFFFFFFFF;
  localparam logic [1:0] OP_MUL = 2'd0, OP_ADD = 2'd1, OP_SUB = 2'd2, OP_NUL = 2'd3;
  localparam logic [1:0] TY_CAL = 2'd0, TY_UPD = 2'd1, TY_FIN = 2'd2, TY_NULL = 2'd3;
  localparam logic [3:0] R_X2 = 4'd0, R_Y2 = 4'd1, R_Z2 = 4'd2, R_T0 = 4'd3, R_T1 = 4'd4;
  localparam logic [3:0] R_T2 = 4'd5, R_X0 = 4'd6, R_Y0 = 4'd7, R_Z0 = 4'd8, R_ZERO = 4'd12;
  localparam int TIMEOUT = 2000;

  logic         clk, rst_n, ins_vld, done;
  logic [15:0]  ins_0, ins_1, ins_2;
  logic [255:0] data_path, x2, y2, z2;

  int           n_checks = 0;
  int           n_fails  = 0;
  logic [255:0] model [12];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sm2_point_cal_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ins_0_i         (ins_0),
    .ins_1_i         (ins_1),
    .ins_2_i         (ins_2),
    .ins_vld_i       (ins_vld),
    .data_path_i     (data_path),
    .var_x2_o        (x2),
    .var_y2_o        (y2),
    .var_z2_o        (z2),
    .intr_cal_done_o (done)
  );

  function automatic logic [15:0] mkIns(input logic [1:0] op, input logic [1:0] ty,
                                        input logic [3:0] a, input logic [3:0] b, input logic [3:0] r);
    return {op, ty, a, b, r};
  endfunction

  function automatic logic [15:0] nop();
    return mkIns(OP_NUL, TY_NULL, 4'd0, 4'd0, 4'd0);
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] modMul(input logic [255:0] a, input logic [255:0] b);
    logic [511:0] prod;
    prod = {256'd0, a} * {256'd0, b};
    prod = prod % {256'd0, P};
    return prod[255:0];
  endfunction

  function automatic logic [255:0] modAdd(input logic [255:0] a, input logic [255:0] b);
    logic [256:0] s;
    s = ({1'b0, a} + {1'b0, b}) % {1'b0, P};
    return s[255:0];
  endfunction

  function automatic logic [255:0] modSub(input logic [255:0] a, input logic [255:0] b);
    logic [256:0] s;
    s = ({1'b0, a} + {1'b0, P} - {1'b0, b}) % {1'b0, P};
    return s[255:0];
  endfunction

  function automatic logic [255:0] modelRead(input logic [3:0] code);
    return (code < 4'd12) ? model[code] : 256'd0;
  endfunction

  task automatic resetModel();
    for (int i = 0; i < 12; i++) model[i] = 256'd0;
`ifdef SM2_BASE_POINT_INIT_EN
    model[6]  = 256'h32C4AE2C1F1981195F9904466A39C9948FE30BBFF2660BE1715A4589334C74C7;
    model[9]  = model[6];
    model[7]  = 256'hBC3736A2F4F6779C59BDCEE36B692153D0A9877CC62A474002DF32E52139F0A0;
    model[10] = model[7];
    model[8]  = 256'd1;
    model[11] = 256'd1;
`endif
  endtask

  // Reference round: every slot reads the pre-round bank, writes land in
  // slot order (later slot wins), FIN copies the new X2/Y2/Z2 last.
  task automatic modelRound(input logic [15:0] i0, input logic [15:0] i1, input logic [15:0] i2,
                            input logic [255:0] d, output int lat);
    logic [15:0]  sl [3];
    logic [255:0] nxt [12];
    logic [255:0] a, b, v;
    bit           w, fin;
    sl[0] = i0; sl[1] = i1; sl[2] = i2;
    for (int i = 0; i < 12; i++) nxt[i] = model[i];
    fin = 0;
    lat = 2;
    for (int s = 0; s < 3; s++) begin
      a = modelRead(sl[s][11:8]);
      b = modelRead(sl[s][7:4]);
      w = 0;
      v = 256'd0;
      lat += (sl[s][13:12] == TY_CAL && sl[s][15:14] == OP_MUL) ? 256 : 1;
      case (sl[s][13:12])
        TY_CAL: begin
          case (sl[s][15:14])
            OP_MUL:  begin w = 1; v = modMul(a, b); end
            OP_ADD:  begin w = 1; v = modAdd(a, b); end
            OP_SUB:  begin w = 1; v = modSub(a, b); end
            default: ;
          endcase
        end
        TY_UPD:  begin w = 1; v = d; end
        TY_FIN:  fin = 1;
        default: ;
      endcase
      if (w && sl[s][3:0] < 4'd12) nxt[sl[s][3:0]] = v;
    end
    if (fin) begin
      nxt[6] = nxt[0];
      nxt[7] = nxt[1];
      nxt[8] = nxt[2];
    end
    for (int i = 0; i < 12; i++) model[i] = nxt[i];
  endtask

  // Issues one round on the next falling edge, waits (bounded) for done, and
  // checks latency and the visible registers. Calling it again right away
  // issues the next round inside the done cycle of this one.
  task automatic applyStimulus(input logic [15:0] i0, input logic [15:0] i1, input logic [15:0] i2,
                               input logic [255:0] d, input bit poke, output int lat);
    int exp_lat;
    modelRound(i0, i1, i2, d, exp_lat);
    @(negedge clk);
    ins_0 = i0; ins_1 = i1; ins_2 = i2; data_path = d; ins_vld = 1'b1;
    @(posedge clk); #1;
    ins_vld = 1'b0;
    checkOutput("done_low_after_vld", {255'd0, done}, 256'd0);
    lat = 1;
    while (!done && lat < TIMEOUT) begin
      if (poke && lat == 3) begin
        ins_vld   = 1'b1;
        ins_0     = mkIns(OP_NUL, TY_UPD, 4'd0, 4'd0, R_X2);
        data_path = 256'h1234;
      end
      @(posedge clk); #1;
      ins_vld = 1'b0;
      lat++;
    end
    if (!done) checkOutput("done_timeout", 256'd0, 256'd1);
    checkOutput("latency", 256'(lat), 256'(exp_lat));
    checkOutput("var_x2", x2, model[0]);
    checkOutput("var_y2", y2, model[1]);
    checkOutput("var_z2", z2, model[2]);
  endtask

  task automatic setReg(input logic [3:0] r, input logic [255:0] v);
    int lat;
    applyStimulus(mkIns(OP_NUL, TY_UPD, 4'd0, 4'd0, r), nop(), nop(), v, 0, lat);
  endtask

  function automatic logic [255:0] randField();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    case ($urandom_range(0, 3))
      0:       v = P - 256'($urandom_range(1, 4));
      1:       v = 256'($urandom_range(0, 15));
      default: if (v >= P) v = v - P;
    endcase
    return v;
  endfunction

  function automatic logic [15:0] randIns();
    logic [1:0] ty;
    int         k;
    k  = $urandom_range(0, 9);
    ty = (k < 6) ? TY_CAL : (k < 8) ? TY_UPD : (k == 8) ? TY_FIN : TY_NULL;
    return mkIns(2'($urandom_range(0, 3)), ty, 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
  endfunction

  initial begin
    int           lat;
    bit           seen_done;
    logic [255:0] big;

    rst_n = 1'b0; ins_vld = 1'b0; ins_0 = '0; ins_1 = '0; ins_2 = '0; data_path = '0;
    resetModel();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    checkOutput("reset_x2", x2, model[0]);
    checkOutput("reset_y2", y2, model[1]);
    checkOutput("reset_z2", z2, model[2]);
    checkOutput("reset_done", {255'd0, done}, 256'd0);

    // Load and add with wrap-around.
    setReg(R_X0, 256'd5);
    setReg(R_T2, P - 256'd1);
    applyStimulus(mkIns(OP_ADD, TY_CAL, R_X0, R_T2, R_X2), nop(), nop(), 256'd0, 0, lat);
    checkOutput("add_wrap_value", x2, 256'd4);
    checkOutput("add_latency_5", 256'(lat), 256'd5);

    // Subtract with borrow.
    setReg(R_X0, 256'd3);
    setReg(R_T2, 256'd5);
    applyStimulus(mkIns(OP_SUB, TY_CAL, R_X0, R_T2, R_Y2), nop(), nop(), 256'd0, 0, lat);
    checkOutput("sub_wrap_value", y2, P - 256'd2);

    // Multiply; a vld strobe while busy must be ignored.
    setReg(R_X0, P - 256'd1);
    applyStimulus(mkIns(OP_MUL, TY_CAL, R_X0, R_X0, R_Z2), nop(), nop(), 256'd0, 1, lat);
    checkOutput("mul_pm1_sq", z2, 256'd1);
    checkOutput("mul_latency_260", 256'(lat), 256'd260);
    checkOutput("busy_vld_ignored_x2", x2, 256'd4);
    big = 256'd1 << 255;
    setReg(R_X0, big);
    applyStimulus(mkIns(OP_MUL, TY_CAL, R_X0, R_X0, R_Z2), nop(), nop(), 256'd0, 0, lat);
    checkOutput("mul_2pow510", z2, modMul(big, big));

    // Parallel semantics: all slots read the round-start values.
    setReg(R_T0, 256'd3);
    setReg(R_X0, 256'd7);
    setReg(R_Y2, 256'd2);
    applyStimulus(mkIns(OP_MUL, TY_CAL, R_X0, R_T0, R_T0), mkIns(OP_MUL, TY_CAL, R_T0, R_T0, R_T1),
                  mkIns(OP_MUL, TY_CAL, R_T0, R_Y2, R_Y2), 256'd0, 0, lat);
    checkOutput("par_y2", y2, 256'd6);
    applyStimulus(mkIns(OP_ADD, TY_CAL, R_T0, R_ZERO, R_X2), mkIns(OP_ADD, TY_CAL, R_T1, R_ZERO, R_Z2),
                  nop(), 256'd0, 0, lat);
    checkOutput("par_t0", x2, 256'd21);
    checkOutput("par_t1", z2, 256'd9);

    // FIN copies the working point into X0/Y0/Z0.
    setReg(R_X2, 256'd11);
    setReg(R_Y2, 256'd22);
    setReg(R_Z2, 256'd33);
    applyStimulus(mkIns(OP_NUL, TY_FIN, 4'd0, 4'd0, 4'd0), nop(), nop(), 256'd0, 0, lat);
    applyStimulus(mkIns(OP_ADD, TY_CAL, R_X0, R_Y0, R_X2), mkIns(OP_ADD, TY_CAL, R_Z0, R_ZERO, R_Z2),
                  nop(), 256'd0, 0, lat);
    checkOutput("fin_x0_plus_y0", x2, 256'd33);
    checkOutput("fin_z0", z2, 256'd33);

    // Reset in the middle of a multiply aborts the round without a done pulse.
    @(negedge clk);
    ins_0 = mkIns(OP_MUL, TY_CAL, R_X0, R_X0, R_X2); ins_1 = nop(); ins_2 = nop(); ins_vld = 1'b1;
    @(posedge clk); #1;
    ins_vld   = 1'b0;
    seen_done = 0;
    repeat (99) begin
      @(posedge clk); #1;
      if (done) seen_done = 1;
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    resetModel();
    checkOutput("midrst_x2", x2, 256'd0);
    checkOutput("midrst_y2", y2, 256'd0);
    checkOutput("midrst_z2", z2, 256'd0);
    repeat (300) begin
      @(posedge clk); #1;
      if (done) seen_done = 1;
    end
    checkOutput("midrst_no_done", {255'd0, seen_done}, 256'd0);
    setReg(R_T1, 256'd9);
    applyStimulus(mkIns(OP_ADD, TY_CAL, R_T1, R_T1, R_Y2), nop(), nop(), 256'd0, 0, lat);
    checkOutput("post_rst_add", y2, 256'd18);

    // Randomized rounds against the model.
    for (int i = 0; i < 25; i++) begin
      applyStimulus(randIns(), randIns(), randIns(), randField(), 0, lat);
    end

    // Expose the hidden registers through X2/Y2/Z2.
    for (int c = 3; c < 12; c += 3) begin
      applyStimulus(mkIns(OP_ADD, TY_CAL, 4'(c), R_ZERO, R_X2), mkIns(OP_ADD, TY_CAL, 4'(c + 1), R_ZERO, R_Y2),
                    mkIns(OP_ADD, TY_CAL, 4'(c + 2), R_ZERO, R_Z2), 256'd0, 0, lat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/sm2_point_cal_unit.md
Name: sm2_point_cal_unit

Overview:
- Instruction-driven SM2 elliptic-curve point arithmetic engine. It executes one "round" of up to three 16-bit instructions over a bank of twelve 256-bit field registers.
- Supported operations: modular multiply, add and subtract mod the SM2 prime p.
- A host sequencer pushes rounds to build point-double and point-add sequences. It receives a done pulse after each round.
- The working result X2/Y2/Z2 is exposed continuously.

Parameters:
- P, 256'hFFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF00000000FFFFFFFFFFFFFFFF, field modulus.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- ins_0_i  in  16  instruction slot 0
- ins_1_i  in  16  instruction slot 1
- ins_2_i  in  16  instruction slot 2
- ins_vld_i  in  1  one-cycle strobe; all three slots are valid in that cycle
- data_path_i  in  256  load data for UPDT_REG
- var_x2_o  out  256  register X2
- var_y2_o  out  256  register Y2
- var_z2_o  out  256  register Z2
- intr_cal_done_o  out  1  one-cycle round-complete pulse

Behaviour:
- Instruction fields:
  - [15:14] op: 00 MUL, 01 ADD, 10 SUB, 11 NUL.
  - [13:12] type: 00 CAL, 01 UPDT_REG, 10 FIN, 11 NULL.
  - [11:8] operand a, [7:4] operand b, [3:0] destination r.
- Register codes: 0 X2, 1 Y2, 2 Z2, 3 T0, 4 T1, 5 T2, 6 X0, 7 Y0, 8 Z0, 9 X1, 10 Y1, 11 Z1.
  - Codes 12-15 read as 0; writes to them are discarded.
- Reset (rst_n=0 at a clock edge):
  - All registers clear to 0; var_*_o=0; intr_cal_done_o=0.
  - FSM returns to IDLE; any round in progress is aborted with no commit.
- FSM states: IDLE, EXEC, COMMIT.
  - In IDLE, ins_vld_i=1 latches all three instructions, snapshots all 12 registers, and captures data_path_i. Next state is EXEC (slot 0).
  - ins_vld_i is ignored outside IDLE.
- Parallel semantics: every slot reads the snapshot taken at round start. Results go to per-slot shadow buffers. All writes commit together in COMMIT.
  - If two slots target the same register, the higher slot index wins.
- Per-slot execution in EXEC, slots processed in order 0, 1, 2:
  - CAL with MUL: interleaved bit-serial modular multiply, MSB first, a*b mod P, 256 cycles.
  - CAL with ADD: (a+b) mod P, 1 cycle; one subtraction of P if the 257-bit sum is ≥ P.
  - CAL with SUB: (a-b) mod P, 1 cycle; add P if borrow.
  - CAL with op NUL: no write, 1 cycle.
  - UPDT_REG: r ← captured data_path_i, 1 cycle.
  - FIN: copy X2→X0, Y2→Y0, Z2→Z0, 1 cycle. It takes effect at commit, after CAL writes from the same round.
  - NULL: no effect, 1 cycle.
- Operands are required to be < P. Results are always < P for reduced operands.
- After slot 2 the FSM moves to COMMIT and writes the registers. In the following cycle intr_cal_done_o=1 for exactly one cycle and the FSM returns to IDLE.
  - A new ins_vld_i is accepted in that same done cycle.
- Latency from the vld edge to the done pulse = 2 + Σ(slot cycles).
  - Three non-MUL slots: 5 cycles.
  - One MUL plus two NULL slots: 260 cycles.
- Outputs are driven directly from the X2/Y2/Z2 registers; they change only at commit or reset.

Optional Feature:
- Macro SM2_BASE_POINT_INIT_EN.
- Defined: reset loads X0=X1=Gx and Y0=Y1=Gy of the SM2 base point, and Z0=Z1=1. Values:
  - Gx = 32C4AE2C1F1981195F9904466A39C9948FE30BBFF2660BE1715A4589334C74C7
  - Gy = BC3736A2F4F6779C59BDCEE36B692153D0A9877CC62A474002DF32E52139F0A0
  - All other registers reset to 0.
- Undefined: every register resets to 0.

Test Plan:
- Load and add: UPDT_REG loads X0=5 and T2=P-1, then CAL ADD X0,T2→X2 with two NULL slots → var_x2_o=4; done pulse 5 cycles after vld.
- Subtract wrap: X0=3, T2=5, SUB X0,T2→Y2 → var_y2_o=P-2.
- Multiply: X0=P-1, MUL X0,X0→Z2 → var_z2_o=1, done 260 cycles after vld. Also X0=2^255: MUL X0,X0 → 2^510 mod P (compare against a golden model).
- Parallel semantics: T0=3, X0=7, Y2=2, with slots MUL X0,T0→T0; MUL T0,T0→T1; MUL T0,Y2→Y2 → T0=21, T1=9, Y2=6.
- FIN: after X2/Y2/Z2=11/22/33, FIN → X0/Y0/Z0=11/22/33, verified by ADD X0,Y0→X2 giving 33. Also: ins_vld_i pulsed while busy is ignored.
- Reset mid-MUL: assert rst_n=0 at cycle 100 → all outputs 0 with no done pulse; the next round works normally.
